// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - pixel stream bundle between the capture pipeline and the A/B sink demux
interface stream_demux_if;
    logic [15:0] pix_in;
    logic        pix_valid_in;
    logic        frame_start_in;
    logic [15:0] pix_out_a;
    logic [15:0] pix_out_b;
    logic        pix_valid_a;
    logic        pix_valid_b;
    logic        frame_start_a;
    logic        frame_start_b;
    logic        route_sel;
    logic        switch_pending;

    modport slave (
        input  pix_in, pix_valid_in, frame_start_in,
        output pix_out_a, pix_out_b, pix_valid_a, pix_valid_b,
        output frame_start_a, frame_start_b, route_sel, switch_pending
    );

    modport master (
        output pix_in, pix_valid_in, frame_start_in,
        input  pix_out_a, pix_out_b, pix_valid_a, pix_valid_b,
        input  frame_start_a, frame_start_b, route_sel, switch_pending
    );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - RGB565 stream demux to sink A/B selected by a debounced button
// FRAME_SYNC_EN: defined applies switches on frame_start_in; undefined applies them on the first idle cycle.
module stream_demux #(
    parameter int CLK_IN_FREQ = 10000000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          sel_btn,
    stream_demux_if.slave bus
);
    localparam int DEBOUNCE_CYCLES = CLK_IN_FREQ / 1000 * DEBOUNCE_MS;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    logic sync_1;
    logic btn_s;

    // Both stages reset to the released level so reset never looks like a press.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            btn_s  <= 1'b1;
        end else begin
            sync_1 <= sel_btn;
            btn_s  <= sync_1;
        end
    end

    db_state_t        db_state;
    db_state_t        db_state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_inc;
    logic             press;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            db_state <= RELEASED;
            cnt      <= '0;
        end else begin
            db_state <= db_state_next;
            cnt      <= cnt_next;
        end
    end

    always_comb begin
        db_state_next = db_state;
        cnt_inc       = 1'b0;
        press         = 1'b0;
        case (db_state)
            RELEASED: begin
                if (!btn_s) begin
                    db_state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    db_state_next = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    db_state_next = PRESSED;
                    press         = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            PRESSED: begin
                if (btn_s) begin
                    db_state_next = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    db_state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    db_state_next = RELEASED;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                db_state_next = RELEASED;
            end
        endcase

        cnt_next = cnt;
        if (db_state_next != db_state) begin
            cnt_next = '0;
        end else if (cnt_inc && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    logic route_q;
    logic pending_q;
    logic apply;
    logic route_next;
    logic pending_next;

`ifdef FRAME_SYNC_EN
    assign apply = pending_q & bus.frame_start_in;
`else
    assign apply = pending_q & ~bus.pix_valid_in;
`endif

    // A press landing on the applying cycle re-arms pending for the next opportunity.
    assign route_next   = route_q ^ apply;
    assign pending_next = apply ? press : (pending_q ^ press);

    logic [15:0] pix_a_q;
    logic [15:0] pix_b_q;
    logic        valid_a_q;
    logic        valid_b_q;
    logic        fs_a_q;
    logic        fs_b_q;

    // Routing uses the post-application route so a switching frame goes wholly to the new sink.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            route_q   <= 1'b0;
            pending_q <= 1'b0;
            pix_a_q   <= 16'h0000;
            pix_b_q   <= 16'h0000;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            fs_a_q    <= 1'b0;
            fs_b_q    <= 1'b0;
        end else begin
            route_q   <= route_next;
            pending_q <= pending_next;
            pix_a_q   <= route_next ? 16'h0000 : bus.pix_in;
            pix_b_q   <= route_next ? bus.pix_in : 16'h0000;
            valid_a_q <= ~route_next & bus.pix_valid_in;
            valid_b_q <= route_next & bus.pix_valid_in;
            fs_a_q    <= ~route_next & bus.frame_start_in;
            fs_b_q    <= route_next & bus.frame_start_in;
        end
    end

    assign bus.pix_out_a      = pix_a_q;
    assign bus.pix_out_b      = pix_b_q;
    assign bus.pix_valid_a    = valid_a_q;
    assign bus.pix_valid_b    = valid_b_q;
    assign bus.frame_start_a  = fs_a_q;
    assign bus.frame_start_b  = fs_b_q;
    assign bus.route_sel      = route_q;
    assign bus.switch_pending = pending_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - randomized and directed bench for stream_demux against a behavioural model
module tb_stream_demux;
    localparam int DC = 10;

    logic clk_in = 1'b0;
    logic rst;
    logic sel_btn;

    stream_demux_if bus ();

    stream_demux #(
        .CLK_IN_FREQ(10000),
        .DEBOUNCE_MS(1)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .sel_btn(sel_btn),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: accepted button level plus a run of samples disagreeing with it.
    bit m_route, m_pend, m_acc, h1, h2;
    int m_run;
    logic [15:0] e_pa, e_pb;
    bit e_va, e_vb, e_fa, e_fb;

    bit prev_sp;
    int obs_rises;
    int obs_rise_cyc;
    int old_sink_valids;
    int new_sink_valids;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_route = 1'b0; m_pend = 1'b0; m_acc = 1'b1; m_run = 0;
        h1 = 1'b1; h2 = 1'b1;
        e_pa = 16'h0; e_pb = 16'h0;
        e_va = 1'b0; e_vb = 1'b0; e_fa = 1'b0; e_fb = 1'b0;
        prev_sp = 1'b0;
    endtask

    task automatic check_all();
        chk("pix_out_a", 32'(bus.pix_out_a), 32'(e_pa));
        chk("pix_out_b", 32'(bus.pix_out_b), 32'(e_pb));
        chk("pix_valid_a", 32'(bus.pix_valid_a), 32'(e_va));
        chk("pix_valid_b", 32'(bus.pix_valid_b), 32'(e_vb));
        chk("frame_start_a", 32'(bus.frame_start_a), 32'(e_fa));
        chk("frame_start_b", 32'(bus.frame_start_b), 32'(e_fb));
        chk("route_sel", 32'(bus.route_sel), 32'(m_route));
        chk("switch_pending", 32'(bus.switch_pending), 32'(m_pend));
    endtask

    task automatic cycle(input bit btn, input logic [15:0] p, input bit v, input bit fs);
        bit s, press, apply;
        sel_btn = btn;
        bus.pix_in = p;
        bus.pix_valid_in = v;
        bus.frame_start_in = fs;
        @(posedge clk_in);
        cyc++;
        // Button seen by the debouncer is the raw level two edges old.
        s = h2; h2 = h1; h1 = btn;
        press = 1'b0;
        if (s != m_acc) begin
            m_run++;
            if (m_run == DC + 1) begin
                m_acc = s;
                m_run = 0;
                press = (s == 1'b0);
            end
        end else begin
            m_run = 0;
        end
`ifdef FRAME_SYNC_EN
        apply = m_pend && fs;
`else
        apply = m_pend && !v;
`endif
        if (apply) begin
            m_route = !m_route;
            m_pend = 1'b0;
        end
        if (press) m_pend = !m_pend;
        e_pa = m_route ? 16'h0 : p;
        e_pb = m_route ? p : 16'h0;
        e_va = !m_route && v;
        e_vb = m_route && v;
        e_fa = !m_route && fs;
        e_fb = m_route && fs;
        #1;
        check_all();
        if (bus.switch_pending && !prev_sp) begin
            obs_rises++;
            obs_rise_cyc = cyc;
        end
        prev_sp = bus.switch_pending;
    endtask

    task automatic idle(input int n, input bit btn);
        for (int i = 0; i < n; i++) cycle(btn, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic clean_press(input bit v);
        for (int i = 0; i < 15; i++) cycle(1'b0, 16'($urandom), v, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 16'($urandom), v, 1'b0);
    endtask

    initial begin
        int t_fall;
        int rises0;
        bit r0;
        bit btn_level;
        int btn_left;

        rst = 1'b1;
        sel_btn = 1'b1;
        bus.pix_in = 16'h0;
        bus.pix_valid_in = 1'b0;
        bus.frame_start_in = 1'b0;
        model_reset();
        obs_rises = 0;
        obs_rise_cyc = 0;
        repeat (2) @(posedge clk_in);
        #1;
        check_all();
        rst = 1'b0;

        // Plain frames to A.
        cycle(1'b1, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 16'($urandom), ($urandom_range(0, 3) != 0), 1'b0);

        // Bounce rejection.
        rises0 = obs_rises;
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        t_fall = cyc + 1;
        for (int i = 0; i < 30; i++) cycle(1'b0, 16'($urandom), 1'b0, 1'b0);
        chk("bounce_rise_count", 32'(obs_rises - rises0), 32'd1);
        chk("bounce_rise_cycle", 32'(obs_rise_cyc), 32'(t_fall + 2 + DC));
        idle(15, 1'b1);

        // Frame alignment: pending (or already applied) switch lands before this frame.
        cycle(1'b1, 16'h0, 1'b0, 1'b1);
        chk("align_route", 32'(bus.route_sel), 32'd1);
        chk("align_fs_b", 32'(bus.frame_start_b), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'h07E0, 1'b1, 1'b0);
            chk("align_pix_b", 32'(bus.pix_out_b), 32'h07E0);
            chk("align_valid_a", 32'(bus.pix_valid_a), 32'd0);
        end

        // Double press within one frame cancels.
        r0 = m_route;
        cycle(1'b1, 16'h0, 1'b0, 1'b1);
        clean_press(1'b1);
        clean_press(1'b1);
        chk("double_pending", 32'(bus.switch_pending), 32'd0);
        cycle(1'b1, 16'h0, 1'b0, 1'b1);
        chk("double_route", 32'(bus.route_sel), 32'(r0));

        // Coincident press with an applying cycle.
        clean_press(1'b1);
        chk("coinc_pre_pending", 32'(bus.switch_pending), 32'd1);
        r0 = m_route;
        for (int i = 0; i <= 12; i++) cycle(1'b0, 16'($urandom), (i != 12), (i == 12));
        chk("coinc_route", 32'(bus.route_sel), 32'(!r0));
        chk("coinc_pending", 32'(bus.switch_pending), 32'd1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 16'h0, 1'b0, 1'b1);
        chk("coinc_route_back", 32'(bus.route_sel), 32'(r0));
        chk("coinc_pending_clear", 32'(bus.switch_pending), 32'd0);

        // Press during an 8-pixel burst; pending sets at i=12, gap at i=16.
        r0 = m_route;
        old_sink_valids = 0;
        new_sink_valids = 0;
        for (int i = 0; i <= 16; i++) begin
            cycle(1'b0, 16'($urandom), (i >= 8 && i < 16), 1'b0);
            if (r0) begin
                old_sink_valids += int'(bus.pix_valid_b);
                new_sink_valids += int'(bus.pix_valid_a);
            end else begin
                old_sink_valids += int'(bus.pix_valid_a);
                new_sink_valids += int'(bus.pix_valid_b);
            end
        end
`ifndef FRAME_SYNC_EN
        chk("burst_old_sink", 32'(old_sink_valids), 32'd8);
        chk("burst_new_sink", 32'(new_sink_valids), 32'd0);
        chk("burst_route_gap", 32'(bus.route_sel), 32'(!r0));
`endif
        idle(15, 1'b1);
        cycle(1'b1, 16'h0, 1'b0, 1'b1);

        // Reset mid-stream.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pix_a", 32'(bus.pix_out_a), 32'd0);
        chk("rst_pix_b", 32'(bus.pix_out_b), 32'd0);
        chk("rst_valid_a", 32'(bus.pix_valid_a), 32'd0);
        chk("rst_valid_b", 32'(bus.pix_valid_b), 32'd0);
        chk("rst_route", 32'(bus.route_sel), 32'd0);
        chk("rst_pending", 32'(bus.switch_pending), 32'd0);
        @(posedge clk_in);
        cyc++;
        #1;
        rst = 1'b0;
        chk("rst_route_release", 32'(bus.route_sel), 32'd0);
        cycle(1'b1, 16'hF800, 1'b1, 1'b0);
        chk("rst_first_pix_a", 32'(bus.pix_out_a), 32'hF800);

        // Randomized traffic and button activity.
        btn_level = 1'b1;
        btn_left = 20;
        for (int i = 0; i < 600; i++) begin
            if (btn_left == 0) begin
                btn_level = !btn_level;
                btn_left = int'($urandom_range(1, 25));
            end
            btn_left--;
            cycle(btn_level, 16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
